// File: rtl/sw_pkg.sv
// Shared types and saturating score helpers for the Smith-Waterman PE array.
// Scores are carried in a wide signed type and clamped to the W-bit range on demand.
package sw_pkg;

  localparam int SCORE_MAX_W = 32;

  typedef logic signed [SCORE_MAX_W-1:0] score_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam score_t SCORE_ZERO = 32'sd0;

  function automatic score_t vmax(input int w);
    score_t one_v;
    one_v = 32'sd1;
    return (one_v <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic score_t ninf(input int w);
    return -vmax(w) - 32'sd1;
  endfunction

  function automatic score_t clamp(input score_t x, input int w);
    if (x > vmax(w)) begin
      return vmax(w);
    end else if (x < ninf(w)) begin
      return ninf(w);
    end else begin
      return x;
    end
  endfunction

  function automatic score_t sat_add(input score_t a, input score_t b, input int w);
    return clamp(a + b, w);
  endfunction

  function automatic score_t sat_sub(input score_t a, input score_t b, input int w);
    return clamp(a - b, w);
  endfunction

  function automatic score_t max2(input score_t a, input score_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_subst_score.sv
// Diagonal (substitution) candidate: vdiag plus match reward or minus mismatch
// penalty, saturated and floored at zero.
module sw_subst_score
  import sw_pkg::*;
#(
  parameter int W     = 12,
  parameter int SYM_W = 2
) (
  input  logic [SYM_W-1:0] s,
  input  logic [SYM_W-1:0] t,
  input  logic [W-1:0]     vdiag,
  input  logic [W-1:0]     cfg_match,
  input  logic [W-1:0]     cfg_mismatch,
  output logic [W-1:0]     d
);

  // Substitution score select and zero floor
  always_comb begin
    d = '0;
    if (s == t) begin
      d = W'(max2(sat_add(score_t'(vdiag), score_t'(cfg_match), W), SCORE_ZERO));
    end else begin
      d = W'(max2(sat_sub(score_t'(vdiag), score_t'(cfg_mismatch), W), SCORE_ZERO));
    end
  end

endmodule

// File: rtl/sw_pe_param.sv
// Smith-Waterman systolic PE with affine gaps: one query symbol per instance,
// one database column per cycle, forwards H/F and the best score with its position.
module sw_pe_param
  import sw_pkg::*;
#(
  parameter int W     = 12,
  parameter int SYM_W = 2,
  parameter int COL_W = 10,
  parameter int ROW_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     cfg_match,
  input  logic [W-1:0]     cfg_mismatch,
  input  logic [W-1:0]     cfg_open,
  input  logic [W-1:0]     cfg_ext,
  input  logic [ROW_W-1:0] row_id,
  input  logic [SYM_W-1:0] s_in,
  input  logic             valid_in,
  input  logic             last_in,
  input  logic [SYM_W-1:0] t_in,
  input  logic [W-1:0]     v_in,
  input  logic [W-1:0]     f_in,
  input  logic [W-1:0]     max_in,
  input  logic [ROW_W-1:0] max_row_in,
  input  logic [COL_W-1:0] max_col_in,
  output logic             valid_out,
  output logic             last_out,
  output logic [SYM_W-1:0] t_out,
  output logic [W-1:0]     v_out,
  output logic [W-1:0]     f_out,
  output logic [W-1:0]     max_out,
  output logic [ROW_W-1:0] max_row_out,
  output logic [COL_W-1:0] max_col_out
);

  localparam logic [COL_W-1:0] COL_SAT = '1;

  state_t             state_r, state_nxt_s;
  logic [SYM_W-1:0]   s_r;
  logic [COL_W-1:0]   col_r, best_col_r;
  logic [W-1:0]       best_r, vdiag_r, e_r, h_r;

  logic               first_s;
  logic [SYM_W-1:0]   s_cur_s;
  logic [COL_W-1:0]   col_cur_s, best_col_cur_s, best_col_new_s;
  logic [W-1:0]       vdiag_cur_s, best_cur_s, best_new_s;
  score_t             e_prev_s, v_left_s;
  logic [W-1:0]       d_s, e_s, f_s, h_s;

  logic [SYM_W-1:0]   nxt_t_s;
  logic [W-1:0]       nxt_v_s, nxt_f_s, nxt_max_s;
  logic [ROW_W-1:0]   nxt_row_s;
  logic [COL_W-1:0]   nxt_col_s;

  // Column context: a first column starts from a clean slate instead of stored state
  always_comb begin
    first_s = valid_in && (state_r == ST_IDLE);
    if (first_s) begin
      s_cur_s        = s_in;
      col_cur_s      = '0;
      vdiag_cur_s    = '0;
      e_prev_s       = ninf(W);
      v_left_s       = SCORE_ZERO;
      best_cur_s     = '0;
      best_col_cur_s = '0;
    end else begin
      s_cur_s        = s_r;
      col_cur_s      = (col_r == COL_SAT) ? col_r : col_r + COL_W'(1);
      vdiag_cur_s    = vdiag_r;
      e_prev_s       = score_t'($signed(e_r));
      v_left_s       = score_t'(h_r);
      best_cur_s     = best_r;
      best_col_cur_s = best_col_r;
    end
  end

  sw_subst_score #(
    .W     (W),
    .SYM_W (SYM_W)
  ) u_subst (
    .s            (s_cur_s),
    .t            (t_in),
    .vdiag        (vdiag_cur_s),
    .cfg_match    (cfg_match),
    .cfg_mismatch (cfg_mismatch),
    .d            (d_s)
  );

  // Cell recurrence and local best; strict compare keeps the earliest column on ties
  always_comb begin
    e_s = W'(max2(sat_sub(e_prev_s, score_t'(cfg_ext), W),
                  sat_sub(v_left_s, score_t'(cfg_open), W)));
    f_s = W'(max2(sat_sub(score_t'($signed(f_in)), score_t'(cfg_ext), W),
                  sat_sub(score_t'(v_in), score_t'(cfg_open), W)));
    h_s = W'(clamp(max2(max2(score_t'(d_s), score_t'($signed(e_s))),
                        max2(score_t'($signed(f_s)), SCORE_ZERO)), W));
    if (h_s > best_cur_s) begin
      best_new_s     = h_s;
      best_col_new_s = col_cur_s;
    end else begin
      best_new_s     = best_cur_s;
      best_col_new_s = best_col_cur_s;
    end
  end

  // Next state and next output values; upstream wins best-score ties
  always_comb begin
    case (state_r)
      ST_IDLE: begin
        if (valid_in && !last_in) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!valid_in || last_in) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    nxt_t_s   = '0;
    nxt_v_s   = '0;
    nxt_f_s   = '0;
    nxt_max_s = '0;
    nxt_row_s = '0;
    nxt_col_s = '0;
    if (valid_in) begin
      nxt_t_s = t_in;
      nxt_v_s = h_s;
      nxt_f_s = f_s;
      if (max_in >= best_new_s) begin
        nxt_max_s = max_in;
        nxt_row_s = max_row_in;
        nxt_col_s = max_col_in;
      end else begin
        nxt_max_s = best_new_s;
        nxt_row_s = row_id;
        nxt_col_s = best_col_new_s;
      end
    end else begin
      nxt_t_s = '0;
    end
  end

  // State, per-query context and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      s_r         <= '0;
      col_r       <= '0;
      best_r      <= '0;
      best_col_r  <= '0;
      vdiag_r     <= '0;
      e_r         <= '0;
      h_r         <= '0;
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
      t_out       <= '0;
      v_out       <= '0;
      f_out       <= '0;
      max_out     <= '0;
      max_row_out <= '0;
      max_col_out <= '0;
    end else begin
      state_r     <= state_nxt_s;
      valid_out   <= valid_in;
      last_out    <= valid_in && last_in;
      t_out       <= nxt_t_s;
      v_out       <= nxt_v_s;
      f_out       <= nxt_f_s;
      max_out     <= nxt_max_s;
      max_row_out <= nxt_row_s;
      max_col_out <= nxt_col_s;
      if (valid_in) begin
        s_r        <= s_cur_s;
        col_r      <= col_cur_s;
        best_r     <= best_new_s;
        best_col_r <= best_col_new_s;
        vdiag_r    <= v_in;
        e_r        <= e_s;
        h_r        <= h_s;
      end
    end
  end

endmodule

// File: tb/tb_sw_pe_param.sv
// Scoreboard bench for sw_pe_param: a two-PE W=12 chain plus a standalone W=8 PE.
// Expected cell values are hand-derived constants queued as each column is driven.
module tb_sw_pe_param;

  typedef struct {
    int v;
    int f;
    int mx;
    int row;
    int c;
    int lst;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q8[$];
  exp_t e0, e1, e8;

  int n_total = 0;
  int n_bad   = 0;

  logic clk = 1'b0;
  logic rst;

  logic [11:0] cfg_match = 12'd8, cfg_mismatch = 12'd5, cfg_open = 12'd7, cfg_ext = 12'd3;
  logic [7:0]  cfg8_match = 8'd8, cfg8_mismatch = 8'd5, cfg8_open = 8'd7, cfg8_ext = 8'd3;

  logic [1:0]  s0, t0, s1;
  logic        valid0, last0;
  logic [11:0] v0, f0;

  logic        vo0, lo0, vo1, lo1;
  logic [1:0]  to0, to1;
  logic [11:0] vout0, fout0, mo0, vout1, fout1, mo1;
  logic [5:0]  mr0, mr1;
  logic [9:0]  mc0, mc1;

  logic [1:0]  s8, t8, to8;
  logic        valid8, last8, vo8, lo8;
  logic [7:0]  v8, f8, vout8, fout8, mo8;
  logic [5:0]  mr8;
  logic [9:0]  mc8;

  sw_pe_param #(.W(12), .SYM_W(2), .COL_W(10), .ROW_W(6)) u_pe0 (
    .clk(clk), .rst(rst),
    .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch), .cfg_open(cfg_open), .cfg_ext(cfg_ext),
    .row_id(6'd0), .s_in(s0), .valid_in(valid0), .last_in(last0), .t_in(t0),
    .v_in(v0), .f_in(f0), .max_in(12'd0), .max_row_in(6'd0), .max_col_in(10'd0),
    .valid_out(vo0), .last_out(lo0), .t_out(to0), .v_out(vout0), .f_out(fout0),
    .max_out(mo0), .max_row_out(mr0), .max_col_out(mc0)
  );

  sw_pe_param #(.W(12), .SYM_W(2), .COL_W(10), .ROW_W(6)) u_pe1 (
    .clk(clk), .rst(rst),
    .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch), .cfg_open(cfg_open), .cfg_ext(cfg_ext),
    .row_id(6'd1), .s_in(s1), .valid_in(vo0), .last_in(lo0), .t_in(to0),
    .v_in(vout0), .f_in(fout0), .max_in(mo0), .max_row_in(mr0), .max_col_in(mc0),
    .valid_out(vo1), .last_out(lo1), .t_out(to1), .v_out(vout1), .f_out(fout1),
    .max_out(mo1), .max_row_out(mr1), .max_col_out(mc1)
  );

  sw_pe_param #(.W(8), .SYM_W(2), .COL_W(10), .ROW_W(6)) u_pe8 (
    .clk(clk), .rst(rst),
    .cfg_match(cfg8_match), .cfg_mismatch(cfg8_mismatch), .cfg_open(cfg8_open), .cfg_ext(cfg8_ext),
    .row_id(6'd0), .s_in(s8), .valid_in(valid8), .last_in(last8), .t_in(t8),
    .v_in(v8), .f_in(f8), .max_in(8'd0), .max_row_in(6'd0), .max_col_in(10'd0),
    .valid_out(vo8), .last_out(lo8), .t_out(to8), .v_out(vout8), .f_out(fout8),
    .max_out(mo8), .max_row_out(mr8), .max_col_out(mc8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int v, input int f, input int mx, input int row, input int c, input int lst);
    exp_t e;
    e.v = v; e.f = f; e.mx = mx; e.row = row; e.c = c; e.lst = lst;
    return e;
  endfunction

  task automatic put0(input logic [1:0] s, input logic [1:0] t, input logic lst, input int v, input exp_t e);
    valid0 = 1'b1; last0 = lst; s0 = s; t0 = t; v0 = 12'(v);
    q0.push_back(e);
  endtask

  task automatic col0(input logic [1:0] s, input logic [1:0] t, input logic lst, input int v, input exp_t e);
    @(posedge clk); #1;
    put0(s, t, lst, v, e);
  endtask

  task automatic idle0();
    @(posedge clk); #1;
    valid0 = 1'b0; last0 = 1'b0; v0 = 12'd0;
  endtask

  task automatic col8(input logic [1:0] s, input logic [1:0] t, input logic lst, input int v, input exp_t e);
    @(posedge clk); #1;
    valid8 = 1'b1; last8 = lst; s8 = s; t8 = t; v8 = 8'(v);
    q8.push_back(e);
  endtask

  // PE0 output scoreboard
  always @(negedge clk) begin
    if (!rst && vo0) begin
      if (q0.size() == 0) begin
        check("pe0_unexpected_valid", q0.size(), 1);
      end else begin
        e0 = q0.pop_front();
        check("pe0_v", vout0, e0.v);
        check("pe0_f", $signed(fout0), e0.f);
        check("pe0_max", mo0, e0.mx);
        check("pe0_row", mr0, e0.row);
        check("pe0_col", mc0, e0.c);
        check("pe0_last", lo0, e0.lst);
      end
    end
  end

  // PE1 output scoreboard, active only while chain expectations are queued
  always @(negedge clk) begin
    if (!rst && vo1 && q1.size() > 0) begin
      e1 = q1.pop_front();
      check("pe1_v", vout1, e1.v);
      check("pe1_f", $signed(fout1), e1.f);
      check("pe1_max", mo1, e1.mx);
      check("pe1_row", mr1, e1.row);
      check("pe1_col", mc1, e1.c);
    end
  end

  // W=8 PE output scoreboard
  always @(negedge clk) begin
    if (!rst && vo8) begin
      if (q8.size() == 0) begin
        check("pe8_unexpected_valid", q8.size(), 1);
      end else begin
        e8 = q8.pop_front();
        check("pe8_v", vout8, e8.v);
        check("pe8_f", $signed(fout8), e8.f);
        check("pe8_max", mo8, e8.mx);
        check("pe8_col", mc8, e8.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s0 = 2'd0; t0 = 2'd0; valid0 = 1'b0; last0 = 1'b0; v0 = 12'd0; f0 = 12'h800;
    s1 = 2'd1;
    s8 = 2'd0; t8 = 2'd0; valid8 = 1'b0; last8 = 1'b0; v8 = 8'd0; f8 = 8'h80;
    #1;
    check("rst_valid", vo0, 0);
    check("rst_v", vout0, 0);
    check("rst_f", fout0, 0);
    check("rst_max", mo0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single PE, s=0, t=0,0,1
    col0(2'd0, 2'd0, 1'b0, 0, mk(8, -7, 8, 0, 0, 0));
    col0(2'd0, 2'd0, 1'b0, 0, mk(8, -7, 8, 0, 0, 0));
    col0(2'd0, 2'd1, 1'b1, 0, mk(1, -7, 8, 0, 0, 1));
    idle0();
    repeat (4) @(posedge clk);

    // two-PE chain, query "01", database "01"
    q1.push_back(mk(1, 1, 8, 0, 0, 0));
    q1.push_back(mk(16, -6, 16, 1, 1, 1));
    col0(2'd0, 2'd0, 1'b0, 0, mk(8, -7, 8, 0, 0, 0));
    col0(2'd0, 2'd1, 1'b1, 0, mk(1, -7, 8, 0, 0, 1));
    idle0();
    repeat (4) @(posedge clk);

    // W=8 saturation at 127
    col8(2'd0, 2'd1, 1'b0, 125, mk(118, 118, 118, 0, 0, 0));
    col8(2'd0, 2'd0, 1'b1, 125, mk(127, 118, 127, 0, 1, 1));
    @(posedge clk); #1;
    valid8 = 1'b0; last8 = 1'b0; v8 = 8'd0;
    repeat (3) @(posedge clk);

    // back-to-back queries without idle cycles
    col0(2'd0, 2'd0, 1'b0, 0, mk(8, -7, 8, 0, 0, 0));
    col0(2'd0, 2'd0, 1'b1, 0, mk(8, -7, 8, 0, 0, 1));
    col0(2'd1, 2'd1, 1'b0, 0, mk(8, -7, 8, 0, 0, 0));
    col0(2'd1, 2'd1, 1'b1, 0, mk(8, -7, 8, 0, 0, 1));
    col0(2'd0, 2'd1, 1'b1, 0, mk(0, -7, 0, 0, 0, 1));
    idle0();
    repeat (4) @(posedge clk);

    // reset pulse mid-query
    col0(2'd0, 2'd0, 1'b0, 0, mk(8, -7, 8, 0, 0, 0));
    col0(2'd0, 2'd0, 1'b0, 0, mk(8, -7, 8, 0, 0, 0));
    @(posedge clk); #1;
    valid0 = 1'b1; s0 = 2'd1; t0 = 2'd1; last0 = 1'b1; v0 = 12'd0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", vo0, 0);
    check("rst_mid_v", vout0, 0);
    check("rst_mid_f", fout0, 0);
    check("rst_mid_max", mo0, 0);
    check("rst_mid_t", to0, 0);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_rel_valid", vo0, 0);
    check("rst_rel_v", vout0, 0);
    q0.push_back(mk(8, -7, 8, 0, 0, 1));
    idle0();
    repeat (4) @(posedge clk);

    // one-cycle valid gap restarts the query
    col0(2'd0, 2'd0, 1'b0, 50, mk(43, 43, 43, 0, 0, 0));
    col0(2'd0, 2'd0, 1'b0, 50, mk(58, 43, 58, 0, 1, 0));
    idle0();
    @(posedge clk); #1;
    put0(2'd0, 2'd0, 1'b1, 0, mk(8, -7, 8, 0, 0, 1));
    @(negedge clk);
    check("gap_valid_out", vo0, 0);
    idle0();
    repeat (5) @(posedge clk);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q8_drained", q8.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
